// File: rtl/sram_rw_ctrl.sv
// Single-port SRAM read/write controller with a 2-entry read-response FIFO.
// Optional power-on zero sweep of the whole array, enabled by SRAM_RW_CTRL_INIT_EN.
module sram_rw_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wmask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              rd_pend_q, rd_pend_d;

  logic       accept;
  logic       push;
  logic       pop;
  logic [2:0] occupancy;
  logic [2:0] occ_after_pop;

`ifdef SRAM_RW_CTRL_INIT_EN
  typedef enum logic [0:0] {StSweep, StReady} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_addr_q, sweep_addr_d;
  logic              sweep_active;

  // Gated by reset_n so the SRAM sees no command while reset is held.
  assign sweep_active = (state_q == StSweep) && reset_n;
  assign init_done    = (state_q == StReady);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StSweep;
      sweep_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    unique case (state_q)
      StSweep: begin
        sweep_addr_d = sweep_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (&sweep_addr_q) begin
          state_d = StReady;
        end
      end
      StReady: begin
        state_d = StReady;
      end
      default: begin
        state_d = StSweep;
      end
    endcase
  end
`else
  logic init_done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= 1'b1;
    end
  end

  assign init_done = init_done_q;
`endif

  assign resp_valid = (count_q != 2'd0);
  assign resp_rdata = fifo_q[rd_ptr_q];
  assign pop        = resp_valid && resp_ready;
  assign push       = rd_pend_q;

  // Reads in flight plus buffered data must fit in the FIFO; a same-cycle pop frees a slot.
  assign occupancy     = {1'b0, count_q} + {2'b00, rd_pend_q};
  assign occ_after_pop = occupancy - {2'b00, pop};
  assign req_ready     = init_done && (occ_after_pop < 3'd2);
  assign accept        = req_valid && req_ready;

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
`ifdef SRAM_RW_CTRL_INIT_EN
    if (sweep_active) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = sweep_addr_q;
      sram_wmask = '1;
      sram_wdata = '0;
    end else if (accept) begin
`else
    if (accept) begin
`endif
      sram_en    = 1'b1;
      sram_wmode = req_write;
      sram_addr  = req_addr;
      sram_wmask = req_wmask;
      sram_wdata = req_wdata;
    end
  end

  always_comb begin
    rd_pend_d = accept && !req_write;
    wr_ptr_d  = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d  = pop ? ~rd_ptr_q : rd_ptr_q;
    count_d   = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= sram_rdata;
      end
    end
  end

endmodule

// File: doc/sram_rw_ctrl.md
SRAM_RW_CTRL -- requirements
Module: sram_rw_ctrl

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 8, SRAM address width.
REQ-002 The block SHALL take parameter DATA_W, default 16, SRAM data and mask width.
REQ-003 Port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port req_valid, input, 1: a request is offered.
REQ-006 Port req_ready, output, 1: a request can be accepted.
REQ-007 Ports req_write (1), req_addr (ADDR_W), req_wmask (DATA_W), req_wdata (DATA_W), inputs: request type, address and write payload.
REQ-008 Port resp_valid, output, 1: read data is available.
REQ-009 Port resp_ready, input, 1: the consumer takes read data.
REQ-010 Port resp_rdata, output, DATA_W: read data, valid while resp_valid=1.
REQ-011 Port init_done, output, 1: the block is open for requests.
REQ-012 Ports sram_en, sram_wmode (1 each), sram_addr (ADDR_W), sram_wmask, sram_wdata (DATA_W), outputs: single-port SRAM command; port sram_rdata, input, DATA_W: SRAM read data.

Function
REQ-013 Accept SHALL equal req_valid && req_ready; a non-accepted cycle SHALL drive sram_en=0, sram_wmode=0, and sram_addr/wmask/wdata=0.
REQ-014 On accept, the SRAM command SHALL be driven combinationally in the same cycle: sram_en=1, sram_wmode=req_write, and sram_addr/wmask/wdata = request fields.
REQ-015 The SRAM read data SHALL be assumed valid exactly one cycle after the read command; the block SHALL register a read-pending flag (rd_pend) on each accepted read.
REQ-016 When rd_pend=1, sram_rdata SHALL be pushed into a 2-entry response FIFO that cycle; FIFO order SHALL equal read-accept order.
REQ-017 resp_valid SHALL be FIFO non-empty; resp_rdata SHALL be the FIFO head, and pop SHALL be resp_valid && resp_ready.
REQ-018 Occupancy SHALL be fifo_count + rd_pend; req_ready SHALL be init_done && (occupancy - pop) < 2, independent of req_write.
REQ-019 Writes SHALL produce no response and SHALL NOT change occupancy.
REQ-020 Simultaneous push and pop SHALL keep fifo_count unchanged; a push into a full FIFO SHALL be impossible by REQ-018.
REQ-021 Sustained reads with resp_ready=1 SHALL achieve one accept per cycle with 2-cycle accept-to-resp_valid latency.
REQ-022 The FIFO read/write pointers SHALL wrap modulo 2.

Reset
REQ-023 While reset_n=0: resp_valid=0, FIFO empty, rd_pend=0, req_ready=0, sram_en=0; init_done SHALL reset per REQ-026/REQ-027.
REQ-024 Reset asserted mid-operation SHALL discard any pending read and buffered data; no response from before reset SHALL ever appear after it.
REQ-025 resp_rdata SHALL reset to 0.

Configuration
REQ-026 With SRAM_RW_CTRL_INIT_EN defined: after reset release, a sweep state machine (SWEEP -> READY) SHALL write address 0..2^ADDR_W-1, one per cycle, with full mask and zero data; init_done SHALL be 0 during SWEEP and SHALL rise the cycle after the last address is written; requests SHALL be refused during the sweep.
REQ-027 Without SRAM_RW_CTRL_INIT_EN: no sweep logic SHALL exist; init_done SHALL be 1 from the first cycle after reset release.

Verification
REQ-028 Write addr 0x05 mask 0xFFFF data 0xA5A5, then read 0x05 -> resp_valid two cycles after read accept, resp_rdata=0xA5A5.
REQ-029 Write 0x10 data 0x1234 full mask, then write 0x10 mask 0x00FF data 0xABCD, then read -> 0x12CD.
REQ-030 Hold resp_ready=0, issue 3 back-to-back reads -> 2 accepted, req_ready=0 on the third; on raising resp_ready, data returns in order.
REQ-031 Read 0x01/0x02/0x03 back-to-back with resp_ready=1 -> 3 accepts in 3 cycles, responses on consecutive cycles, in order.
REQ-032 Assert reset_n=0 the cycle after a read accept -> after release, resp_valid stays 0 with no stale response.
REQ-033 With SRAM_RW_CTRL_INIT_EN, ADDR_W=8 -> init_done rises 256 cycles after reset release; a read of 0xFF then returns 0x0000.
